// File: rtl/pixel_fetch.sv
// pixel_fetch: streams one IMG_W x IMG_H frame from synchronous-read memory as valid/ready pixels.
// Define PIXEL_THRESH_EN to binarise each byte against THRESH (255 if >= THRESH, else 0).
module pixel_fetch #(
  parameter int IMG_W     = 28,
  parameter int IMG_H     = 28,
  parameter int ADDR_W    = 10,
  parameter int BASE_ADDR = 0,
  parameter int THRESH    = 128
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rdata,
  output logic [7:0]        pix_data,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic              pix_last,
  output logic [4:0]        pix_row,
  output logic [4:0]        pix_col
);

  localparam int NPIX  = IMG_W * IMG_H;
  localparam int CNT_W = $clog2(NPIX + 1);

`ifdef PIXEL_THRESH_EN
  localparam bit THRESH_ON = 1'b1;
`else
  localparam bit THRESH_ON = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;

  state_t           state;
  logic [CNT_W-1:0] rd_cnt;
  logic [4:0]       out_row;
  logic [4:0]       out_col;
  logic             ret;
  logic [7:0]       slot [2];
  logic             rd_ptr;
  logic             wr_ptr;
  logic [1:0]       fifo_cnt;
  logic [7:0]       ret_byte;
  logic             credit;
  logic             hs;
  logic             push;
  logic             pop;
  logic             at_last;

  assign ret_byte = THRESH_ON ? ((mem_rdata >= 8'(THRESH)) ? 8'hFF : 8'h00) : mem_rdata;

  // ret marks a byte on mem_rdata this cycle; counting it with the FIFO caps outstanding bytes at two
  assign credit   = (fifo_cnt == 2'd0) || ((fifo_cnt == 2'd1) && !ret);
  assign mem_rd   = (state == FETCH) && credit;
  assign mem_addr = mem_rd ? (ADDR_W'(BASE_ADDR) + ADDR_W'(rd_cnt)) : '0;

  // An empty FIFO lets a returning byte bypass straight to the output, giving latency 2
  assign pix_valid = ret || (fifo_cnt != 2'd0);
  assign pix_data  = ((fifo_cnt == 2'd0) && ret) ? ret_byte : slot[rd_ptr];
  assign at_last   = (out_row == 5'(IMG_H - 1)) && (out_col == 5'(IMG_W - 1));
  assign pix_last  = pix_valid && at_last;
  assign pix_row   = out_row;
  assign pix_col   = out_col;

  assign hs   = pix_valid && pix_ready;
  assign push = ret && !((fifo_cnt == 2'd0) && pix_ready);
  assign pop  = hs && (fifo_cnt != 2'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ret      <= 1'b0;
      fifo_cnt <= 2'd0;
      rd_ptr   <= 1'b0;
      wr_ptr   <= 1'b0;
      slot[0]  <= 8'd0;
      slot[1]  <= 8'd0;
    end else begin
      ret <= mem_rd;
      if (push) begin
        slot[wr_ptr] <= ret_byte;
        wr_ptr       <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      fifo_cnt <= fifo_cnt + 2'(push) - 2'(pop);
    end
  end

  // Output tags follow handshakes, so they always describe the FIFO head
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      rd_cnt  <= '0;
      out_row <= 5'd0;
      out_col <= 5'd0;
    end else begin
      done <= 1'b0;
      if (hs) begin
        if (out_col == 5'(IMG_W - 1)) begin
          out_col <= 5'd0;
          out_row <= at_last ? 5'd0 : out_row + 5'd1;
        end else begin
          out_col <= out_col + 5'd1;
        end
      end
      if (mem_rd) begin
        rd_cnt <= rd_cnt + CNT_W'(1);
      end
      case (state)
        IDLE: begin
          if (start) begin
            state   <= FETCH;
            busy    <= 1'b1;
            rd_cnt  <= '0;
            out_row <= 5'd0;
            out_col <= 5'd0;
          end
        end
        FETCH: begin
          if (mem_rd && (rd_cnt == CNT_W'(NPIX - 1))) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if (hs && at_last) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pixel_fetch.sv
// tb_pixel_fetch: scoreboard bench for pixel_fetch with a memory model and random back-pressure.
// Base address 16 exercises the address offset on a full 28x28 frame.
module tb_pixel_fetch;

  localparam int IMG_W     = 28;
  localparam int IMG_H     = 28;
  localparam int ADDR_W    = 10;
  localparam int BASE_ADDR = 16;
  localparam int THRESH    = 128;
  localparam int NPIX      = IMG_W * IMG_H;

  typedef struct packed {
    logic [7:0] data;
    logic [4:0] row;
    logic [4:0] col;
    logic       last;
  } pix_t;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              start = 1'b0;
  logic              pix_ready = 1'b0;
  logic              busy;
  logic              done;
  logic              mem_rd;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_rdata = 8'd0;
  logic [7:0]        pix_data;
  logic              pix_valid;
  logic              pix_last;
  logic [4:0]        pix_row;
  logic [4:0]        pix_col;

  logic [7:0] mem [0:(1<<ADDR_W)-1];
  pix_t       exp_q[$];
  pix_t       held;
  bit         stall_prev = 1'b0;
  int         tests = 0;
  int         fails = 0;
  int         cyc = 0;
  int         done_cnt = 0;
  int         done_cyc = -1;
  int         first_valid_cyc = -1;
  int         hs_cnt = 0;
  int         rd_issued = 0;

  pixel_fetch #(
    .IMG_W(IMG_W), .IMG_H(IMG_H), .ADDR_W(ADDR_W), .BASE_ADDR(BASE_ADDR), .THRESH(THRESH)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .pix_data(pix_data), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .pix_last(pix_last), .pix_row(pix_row), .pix_col(pix_col)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_rd) mem_rdata <= mem[mem_addr];
  end

  function automatic logic [7:0] expByte(input logic [7:0] b);
`ifdef PIXEL_THRESH_EN
    return (b >= 8'(THRESH)) ? 8'd255 : 8'd0;
`else
    return b;
`endif
  endfunction

  function automatic void pushFrame();
    pix_t p;
    for (int r = 0; r < IMG_H; r++) begin
      for (int c = 0; c < IMG_W; c++) begin
        p.data = expByte(mem[BASE_ADDR + r * IMG_W + c]);
        p.row  = 5'(r);
        p.col  = 5'(c);
        p.last = (r == IMG_H - 1) && (c == IMG_W - 1);
        exp_q.push_back(p);
      end
    end
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h required 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic checkResetValues();
    checkOutput("rst_busy", 32'(busy), 0);
    checkOutput("rst_done", 32'(done), 0);
    checkOutput("rst_mem_rd", 32'(mem_rd), 0);
    checkOutput("rst_mem_addr", 32'(mem_addr), 0);
    checkOutput("rst_pix_valid", 32'(pix_valid), 0);
    checkOutput("rst_pix_data", 32'(pix_data), 0);
    checkOutput("rst_pix_last", 32'(pix_last), 0);
    checkOutput("rst_pix_row", 32'(pix_row), 0);
    checkOutput("rst_pix_col", 32'(pix_col), 0);
  endtask

  // Monitor: pops the scoreboard on each handshake and checks stall stability and credit
  always @(negedge clk) begin
    pix_t p;
    if (rst_n) begin
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        checkOutput("busy_low_at_done", 32'(busy), 0);
      end
      if (pix_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (stall_prev) begin
        checkOutput("stall_hold", 32'({pix_valid, pix_data, pix_row, pix_col, pix_last}), 32'({1'b1, held}));
      end
      if (mem_rd) begin
        rd_issued++;
        checkOutput("outstanding_le2", 32'((rd_issued - hs_cnt) <= 2), 1);
      end
      if (pix_valid && pix_ready) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("[TB] FAIL unexpected_pixel: got data 0x%0h row %0d col %0d, required no pixel (cycle %0d)",
                   pix_data, pix_row, pix_col, cyc);
        end else begin
          p = exp_q.pop_front();
          checkOutput("pixel", 32'({pix_data, pix_row, pix_col, pix_last}), 32'(p));
        end
        hs_cnt++;
      end
      stall_prev = pix_valid && !pix_ready;
      held = '{pix_data, pix_row, pix_col, pix_last};
    end else begin
      stall_prev = 1'b0;
    end
  end

  task automatic applyStimulus(input bit rand_ready, input bit spurious);
    int s;
    int post;
    first_valid_cyc = -1;
    done_cnt        = 0;
    done_cyc        = -1;
    hs_cnt          = 0;
    rd_issued       = 0;
    pushFrame();
    @(posedge clk); #1;
    start     = 1'b1;
    s         = cyc;
    pix_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    post      = 0;
    for (int k = 0; k < 20000 && post < 4; k++) begin
      @(posedge clk); #1;
      start     = spurious && ((cyc - s == 5) || (cyc - s == 100));
      pix_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (cyc == s + 1) begin
        checkOutput("busy_after_start", 32'(busy), 1);
        checkOutput("first_read", 32'({mem_rd, mem_addr}), 32'({1'b1, ADDR_W'(BASE_ADDR)}));
      end
      if (done_cnt > 0) post++;
    end
    start = 1'b0;
    checkOutput("done_seen", 32'(done_cnt > 0), 1);
    checkOutput("one_done", 32'(done_cnt), 1);
    checkOutput("all_pixels_out", 32'(exp_q.size()), 0);
    checkOutput("idle_after_frame", 32'(busy), 0);
    if (!rand_ready) begin
      checkOutput("first_valid_cycle", 32'(first_valid_cyc), 32'(s + 2));
      checkOutput("done_cycle", 32'(done_cyc), 32'(s + NPIX + 2));
    end
    exp_q.delete();
  endtask

  initial begin
    for (int a = 0; a < (1 << ADDR_W); a++) mem[a] = 8'(a);
    #3 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkResetValues();
    rst_n = 1'b1;

    $display("[TB] ramp frame, ready held high");
    applyStimulus(1'b0, 1'b0);

    $display("[TB] random frame, random ready, start pulses while busy");
    for (int a = 0; a < (1 << ADDR_W); a++) mem[a] = 8'($urandom);
    applyStimulus(1'b1, 1'b1);

    $display("[TB] reset mid-frame then restart");
    for (int a = 0; a < (1 << ADDR_W); a++) mem[a] = 8'($urandom);
    hs_cnt    = 0;
    rd_issued = 0;
    pushFrame();
    @(posedge clk); #1;
    start = 1'b1;
    for (int k = 0; k < 5000 && hs_cnt < 300; k++) begin
      @(posedge clk); #1;
      start     = 1'b0;
      pix_ready = 1'($urandom_range(0, 1));
    end
    checkOutput("reached_pixel_300", 32'(hs_cnt >= 300), 1);
    rst_n = 1'b0;
    #2;
    checkResetValues();
    exp_q.delete();
    repeat (3) @(posedge clk);
    #1;
    checkResetValues();
    rst_n = 1'b1;
    applyStimulus(1'b1, 1'b0);

    $display("[TB] threshold boundary bytes");
    mem[BASE_ADDR + 0] = 8'd127;
    mem[BASE_ADDR + 1] = 8'd128;
    mem[BASE_ADDR + 2] = 8'd0;
    mem[BASE_ADDR + 3] = 8'd255;
    applyStimulus(1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
